// File: rtl/alu_seq.sv
// alu_seq: multicycle sequencer for one register-to-register instruction at a
// time on an external regfile / alucontrol / alu datapath.
// Optional build macro: ALU_SEQ_R0_PROTECT_EN (register 0 is never written).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cmd_ready high, waiting for a command handshake
// S_READ  | regfile read addresses driven, operands latched at the end
// S_EXEC  | ALU operands stable, result and write address latched at end
// S_WRITE | regwrite/done asserted for one cycle, counter bumps at end
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ldi,
  input  logic [1:0]       cmd_aluop,
  input  logic [5:0]       cmd_funct,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs,
  input  logic [AW-1:0]    cmd_rt,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [AW-1:0]    ra1,
  output logic [AW-1:0]    ra2,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic [AW-1:0]    wa,
  output logic [WIDTH-1:0] wd,
  output logic             regwrite,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       aluop,
  output logic [5:0]       funct,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] done_result,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t             r_state, w_state;
  logic               r_cmd_ready, w_cmd_ready;
  logic [AW-1:0]      r_ra1, w_ra1, r_ra2, w_ra2, r_wa, w_wa;
  logic [WIDTH-1:0]   r_wd, w_wd, r_a, w_a, r_b, w_b;
  logic               r_regwrite, w_regwrite, r_done, w_done, r_busy, w_busy;
  logic [1:0]         r_aluop, w_aluop, r_cap_aluop, w_cap_aluop;
  logic [5:0]         r_funct, w_funct, r_cap_funct, w_cap_funct;
  logic [AW-1:0]      r_cap_rd, w_cap_rd;
  logic [WIDTH-1:0]   r_done_result, w_done_result;
  logic [CNT_W-1:0]   r_instr_count, w_instr_count;

  // Next-state and next-output logic; every output is registered, so the
  // values a state must present are computed on the edge that enters it.
  always_comb begin
    w_state       = r_state;
    w_cmd_ready   = r_cmd_ready;
    w_ra1         = r_ra1;
    w_ra2         = r_ra2;
    w_wa          = r_wa;
    w_wd          = r_wd;
    w_a           = r_a;
    w_b           = r_b;
    w_aluop       = r_aluop;
    w_funct       = r_funct;
    w_cap_aluop   = r_cap_aluop;
    w_cap_funct   = r_cap_funct;
    w_cap_rd      = r_cap_rd;
    w_busy        = r_busy;
    w_done_result = r_done_result;
    w_instr_count = r_instr_count;
    w_regwrite    = 1'b0;
    w_done        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_cap_aluop = cmd_aluop;
          w_cap_funct = cmd_funct;
          w_cap_rd    = cmd_rd;
          w_cmd_ready = 1'b0;
          w_busy      = 1'b1;
          if (cmd_ldi) begin
            w_wa    = cmd_rd;
            w_wd    = cmd_imm;
            w_state = S_WRITE;
          end else begin
            w_ra1   = cmd_rs;
            w_ra2   = cmd_rt;
            w_state = S_READ;
          end
        end
      end
      S_READ: begin
        w_a       = rd1;
        w_b       = rd2;
        w_aluop   = r_cap_aluop;
        w_funct   = r_cap_funct;
        w_state   = S_EXEC;
      end
      S_EXEC: begin
        w_wd      = result;
        w_wa      = r_cap_rd;
        w_state   = S_WRITE;
      end
      S_WRITE: begin
        w_instr_count = r_instr_count + CNT_W'(1);
        w_cmd_ready   = 1'b1;
        w_busy        = 1'b0;
        w_state       = S_IDLE;
      end
      default: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        w_state     = S_IDLE;
      end
    endcase

    // Entering WRITE from either path: raise the one-cycle write/done pulse.
    if (w_state == S_WRITE && r_state != S_WRITE) begin
      w_regwrite    = 1'b1;
      w_done        = 1'b1;
      w_done_result = w_wd;
`ifdef ALU_SEQ_R0_PROTECT_EN
      if (w_wa == '0) begin
        w_regwrite    = 1'b0;
        w_done_result = '0;
      end
`endif
    end
  end

  // State and output registers; reset forces IDLE and kills any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_ra1         <= '0;
      r_ra2         <= '0;
      r_wa          <= '0;
      r_wd          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_aluop       <= '0;
      r_funct       <= '0;
      r_cap_aluop   <= '0;
      r_cap_funct   <= '0;
      r_cap_rd      <= '0;
      r_regwrite    <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_done_result <= '0;
      r_instr_count <= '0;
    end else begin
      r_state       <= w_state;
      r_cmd_ready   <= w_cmd_ready;
      r_ra1         <= w_ra1;
      r_ra2         <= w_ra2;
      r_wa          <= w_wa;
      r_wd          <= w_wd;
      r_a           <= w_a;
      r_b           <= w_b;
      r_aluop       <= w_aluop;
      r_funct       <= w_funct;
      r_cap_aluop   <= w_cap_aluop;
      r_cap_funct   <= w_cap_funct;
      r_cap_rd      <= w_cap_rd;
      r_regwrite    <= w_regwrite;
      r_done        <= w_done;
      r_busy        <= w_busy;
      r_done_result <= w_done_result;
      r_instr_count <= w_instr_count;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign ra1         = r_ra1;
  assign ra2         = r_ra2;
  assign wa          = r_wa;
  assign wd          = r_wd;
  assign regwrite    = r_regwrite;
  assign a           = r_a;
  assign b           = r_b;
  assign aluop       = r_aluop;
  assign funct       = r_funct;
  assign busy        = r_busy;
  assign done        = r_done;
  assign done_result = r_done_result;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural regfile and ALU around it.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_ldi = 1'b0;
  logic [1:0]  cmd_aluop = 2'b00;
  logic [5:0]  cmd_funct = 6'd0;
  logic [2:0]  cmd_rd = 3'd0, cmd_rs = 3'd0, cmd_rt = 3'd0;
  logic [7:0]  cmd_imm = 8'd0;
  logic [2:0]  ra1, ra2, wa;
  logic [7:0]  rd1, rd2, wd, a, b, result, done_result;
  logic        regwrite, busy, done;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [15:0] instr_count;

  logic        tb_clr = 1'b1;
  logic [7:0]  rf [0:7];

  int n_chk  = 0;
  int n_pass = 0;

  alu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ldi(cmd_ldi),
    .cmd_aluop(cmd_aluop), .cmd_funct(cmd_funct), .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa(wa), .wd(wd), .regwrite(regwrite),
    .a(a), .b(b), .aluop(aluop), .funct(funct), .result(result),
    .busy(busy), .done(done), .done_result(done_result),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Behavioural regfile: combinational read, write on posedge.
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
    end else if (regwrite) begin
      rf[wa] <= wd;
    end
  end
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  // Behavioural alucontrol + ALU.
  always_comb begin
    result = 8'd0;
    case (aluop)
      2'b00: result = a + b;
      2'b01: result = a - b;
      2'b11: begin
        case (funct)
          6'b100000: result = a + b;
          6'b100010: result = a - b;
          6'b100100: result = a & b;
          6'b100101: result = a | b;
          6'b101010: result = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
          default:   result = 8'd0;
        endcase
      end
      default: result = 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic do_cmd(input logic ldi, input logic [1:0] op, input logic [5:0] fn,
                        input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [7:0] imm, output int lat, output logic [7:0] dres);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_ldi = ldi; cmd_aluop = op; cmd_funct = fn;
    cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    dres = 8'hxx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        dres = done_result;
        break;
      end
    end
    @(negedge clk);
  endtask

  int         lat;
  logic [7:0] dres;
  int         acc_cyc [2];
  int         k, cyc, low_cnt;

  typedef struct { logic [5:0] fn; logic [2:0] rd; logic [7:0] exp; } rvec_t;
  rvec_t rvec [5];

  initial begin
    rvec[0] = '{6'b100000, 3'd3, 8'd3};
    rvec[1] = '{6'b100010, 3'd4, 8'd255};
    rvec[2] = '{6'b100100, 3'd5, 8'd0};
    rvec[3] = '{6'b100101, 3'd6, 8'd3};
    rvec[4] = '{6'b101010, 3'd7, 8'd1};

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    tb_clr = 1'b0;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_outs", {regwrite, busy, done, done_result, wd, wa, a, b},
          32'd0);
    check("rst_outs2", {ra1, ra2, aluop, funct, instr_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_count", 32'(instr_count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Two LDIs
    do_cmd(1'b1, 2'b00, 6'd0, 3'd1, 3'd0, 3'd0, 8'd1, lat, dres);
    check("ldi1_lat", 32'(lat), 32'd1);
    check("ldi1_res", 32'(dres), 32'd1);
    do_cmd(1'b1, 2'b00, 6'd0, 3'd2, 3'd0, 3'd0, 8'd2, lat, dres);
    check("ldi2_lat", 32'(lat), 32'd1);
    check("ldi2_res", 32'(dres), 32'd2);
    check("ldi_count", 32'(instr_count), 32'd2);

    // R-type ops on r1=1, r2=2
    for (int i = 0; i < 5; i++) begin
      do_cmd(1'b0, 2'b11, rvec[i].fn, rvec[i].rd, 3'd1, 3'd2, 8'd0, lat, dres);
      check("rop_lat", 32'(lat), 32'd3);
      check("rop_res", 32'(dres), 32'(rvec[i].exp));
      check("rop_reg", 32'(rf[rvec[i].rd]), 32'(rvec[i].exp));
    end
    check("rop_count", 32'(instr_count), 32'd7);

    // Back-to-back with cmd_valid held: r3=r1+r2 then dependent r4=r3+r3
    cmd_ldi = 1'b0; cmd_aluop = 2'b11; cmd_funct = 6'b100000;
    cmd_rd = 3'd3; cmd_rs = 3'd1; cmd_rt = 3'd2;
    cmd_valid = 1'b1;
    k = 0; cyc = 0; low_cnt = 0;
    while (k < 2 && cyc < 20) begin
      if (cmd_ready) begin
        acc_cyc[k] = cyc;
        k++;
        @(posedge clk);
        #1;
        if (k == 1) begin
          cmd_rd = 3'd4; cmd_rs = 3'd3; cmd_rt = 3'd3;
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        low_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_accepts", 32'(k), 32'd2);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("b2b_ready_low", 32'(low_cnt), 32'd3);
    repeat (4) @(negedge clk);
    check("dep_r4", 32'(rf[4]), 32'd6);
    check("b2b_count", 32'(instr_count), 32'd9);

    // Reset during EXEC of add to r5 (r5 currently 0)
    cmd_ldi = 1'b0; cmd_aluop = 2'b11; cmd_funct = 6'b100000;
    cmd_rd = 3'd5; cmd_rs = 3'd1; cmd_rt = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rw", 32'(regwrite), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_count", 32'(instr_count), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_rw_hold", 32'(regwrite), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_r5", 32'(rf[5]), 32'd0);
    do_cmd(1'b0, 2'b11, 6'b100000, 3'd5, 3'd1, 3'd2, 8'd0, lat, dres);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_r5", 32'(rf[5]), 32'd3);
    check("post_rst_count", 32'(instr_count), 32'd1);

    // LDI to r0
    do_cmd(1'b1, 2'b00, 6'd0, 3'd0, 3'd0, 3'd0, 8'h55, lat, dres);
    check("r0_lat", 32'(lat), 32'd1);
    check("r0_count", 32'(instr_count), 32'd2);
`ifdef ALU_SEQ_R0_PROTECT_EN
    check("r0_res", 32'(dres), 32'd0);
    check("r0_reg", 32'(rf[0]), 32'd0);
`else
    check("r0_res", 32'(dres), 32'h55);
    check("r0_reg", 32'(rf[0]), 32'h55);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
